// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle linking the pipeline's fetch and data sides, the arbiter and the memory port.
// master is the arbiter's view; slave is the surrounding pipeline-plus-memory view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_cancel;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_data_ok;
    logic                  i_stall;

    logic                  d_req;
    logic                  d_wr;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_data_ok;
    logic                  d_stall;

    logic                  mem_req;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        input  i_req, i_addr, i_cancel,
        output i_rdata, i_data_ok, i_stall,
        input  d_req, d_wr, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_data_ok, d_stall,
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        output i_req, i_addr, i_cancel,
        input  i_rdata, i_data_ok, i_stall,
        output d_req, d_wr, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_data_ok, d_stall,
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one SRAM-like port, one transaction in flight.
// Define ARB_FAIR_EN to let a waiting fetch win after FAIR_LIMIT consecutive data grants.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic              own_q, own_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              i_ok_q, i_ok_d;
    logic              d_ok_q, d_ok_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_cand, d_cand, grant_i, grant_d;

    // A side whose completion is pulsing still holds its old request, so it sits this round out.
    assign i_cand = bus.i_req && !bus.i_cancel && !i_ok_q;
    assign d_cand = bus.d_req && !d_ok_q;

`ifdef ARB_FAIR_EN
    localparam int CNT_W = $clog2(FAIR_LIMIT + 1);
    logic [CNT_W-1:0] fair_cnt_q, fair_cnt_d;

    assign grant_i = i_cand && (!d_cand || fair_cnt_q == CNT_W'(FAIR_LIMIT));
    assign grant_d = d_cand && !grant_i;

    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (state_q == IDLE) begin
            if (grant_i)
                fair_cnt_d = '0;
            else if (grant_d && i_cand)
                fair_cnt_d = fair_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fair_cnt_q <= '0;
        else     fair_cnt_q <= fair_cnt_d;
    end
`else
    assign grant_d = d_cand;
    assign grant_i = i_cand && !d_cand;
`endif

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        kill_d    = kill_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        i_ok_d    = 1'b0;
        d_ok_d    = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    own_d   = 1'b1;
                    addr_d  = bus.d_addr;
                    wr_d    = bus.d_wr;
                    wdata_d = bus.d_wdata;
                    wstrb_d = bus.d_wr ? bus.d_wstrb : '0;
                    state_d = ADDR;
                end else if (grant_i) begin
                    own_d   = 1'b0;
                    addr_d  = bus.i_addr;
                    wr_d    = 1'b0;
                    wstrb_d = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!own_q && bus.i_cancel) kill_d = 1'b1;
                if (bus.mem_addr_ok) state_d = DATA;
            end
            DATA: begin
                if (!own_q && bus.i_cancel) kill_d = 1'b1;
                if (bus.mem_data_ok) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (own_q) begin
                        d_ok_d    = 1'b1;
                        d_rdata_d = bus.mem_rdata;
                    end else if (!(kill_q || bus.i_cancel)) begin
                        i_ok_d    = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            kill_q    <= 1'b0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            i_ok_q    <= 1'b0;
            d_ok_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            kill_q    <= kill_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            i_ok_q    <= i_ok_d;
            d_ok_q    <= d_ok_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.mem_req   = (state_q == ADDR);
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_data_ok = i_ok_q;
    assign bus.d_data_ok = d_ok_q;
    assign bus.i_stall   = bus.i_req && !i_ok_q;
    assign bus.d_stall   = bus.d_req && !d_ok_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level arbiter model.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

`ifdef ARB_FAIR_EN
    localparam int FAIR_LIMIT = 4;
    int fairCnt = 0;
`endif

    // Random-phase requester, memory and model state
    logic        iPend, dPend, dWr;
    logic [31:0] iAddr, dAddr, dWdata;
    logic [3:0]  dWstrb;
    logic        txnActive, txnD, txnWr;
    int          txnPhase;
    logic [31:0] txnAddr, txnWdata, pendData, lastI, lastD, rd;
    logic [3:0]  txnWstrb;
    logic        pulseI, pulseD, expI, expD, candI, candD, grantI, grantD;
    logic        addrOk, dataOk, expMemReq;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iA, input logic iCancel,
                                 input logic dReq, input logic dW, input logic [31:0] dA,
                                 input logic [31:0] dWd, input logic [3:0] dS);
        bus.i_req    = iReq;
        bus.i_addr   = iA;
        bus.i_cancel = iCancel;
        bus.d_req    = dReq;
        bus.d_wr     = dW;
        bus.d_addr   = dA;
        bus.d_wdata  = dWd;
        bus.d_wstrb  = dS;
    endtask

    task automatic memRespond(input logic aOk, input logic dOk, input logic [31:0] data);
        bus.mem_addr_ok = aOk;
        bus.mem_data_ok = dOk;
        bus.mem_rdata   = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        $display("[TB] mem_bus_arbiter bench starting");
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 0, 0);
        nextCycle();
        nextCycle();
        checkOutput("reset mem_req",   bus.mem_req,   0);
        checkOutput("reset mem_wr",    bus.mem_wr,    0);
        checkOutput("reset mem_addr",  bus.mem_addr,  0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 0);
        checkOutput("reset mem_wstrb", bus.mem_wstrb, 0);
        checkOutput("reset i_data_ok", bus.i_data_ok, 0);
        checkOutput("reset d_data_ok", bus.d_data_ok, 0);
        checkOutput("reset i_rdata",   bus.i_rdata,   0);
        checkOutput("reset d_rdata",   bus.d_rdata,   0);
        rst = 1'b0;
        nextCycle();

        // Single fetch at minimum latency
        applyStimulus(1, 32'h1000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("fetch c0 i_stall", bus.i_stall, 1);
        checkOutput("fetch c0 mem_req", bus.mem_req, 0);
        nextCycle(); memRespond(1, 0, 0);
        #1 checkOutput("fetch c1 mem_req", bus.mem_req, 1);
        checkOutput("fetch c1 mem_addr", bus.mem_addr, 32'h1000);
        checkOutput("fetch c1 mem_wr", bus.mem_wr, 0);
        checkOutput("fetch c1 mem_wstrb", bus.mem_wstrb, 0);
        checkOutput("fetch c1 i_stall", bus.i_stall, 1);
        nextCycle(); memRespond(0, 1, 32'hDEADBEEF);
        #1 checkOutput("fetch c2 mem_req", bus.mem_req, 0);
        checkOutput("fetch c2 i_stall", bus.i_stall, 1);
        checkOutput("fetch c2 i_data_ok", bus.i_data_ok, 0);
        nextCycle(); memRespond(0, 0, 0);
        applyStimulus(0, 32'h1000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("fetch c3 i_data_ok", bus.i_data_ok, 1);
        checkOutput("fetch c3 i_rdata", bus.i_rdata, 32'hDEADBEEF);
        checkOutput("fetch c3 i_stall", bus.i_stall, 0);
        nextCycle();
        #1 checkOutput("fetch c4 i_data_ok", bus.i_data_ok, 0);
        checkOutput("fetch c4 mem_req", bus.mem_req, 0);

        // Store with partial strobes
        applyStimulus(0, 0, 0, 1, 1, 32'h2004, 32'h12345678, 4'b0011);
        #1 checkOutput("store c0 d_stall", bus.d_stall, 1);
        nextCycle(); memRespond(1, 0, 0);
        #1 checkOutput("store c1 mem_req", bus.mem_req, 1);
        checkOutput("store c1 mem_wr", bus.mem_wr, 1);
        checkOutput("store c1 mem_wstrb", bus.mem_wstrb, 4'b0011);
        checkOutput("store c1 mem_addr", bus.mem_addr, 32'h2004);
        checkOutput("store c1 mem_wdata", bus.mem_wdata, 32'h12345678);
        nextCycle(); memRespond(0, 1, 0);
        #1 checkOutput("store c2 d_data_ok", bus.d_data_ok, 0);
        nextCycle(); memRespond(0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("store c3 d_data_ok", bus.d_data_ok, 1);
        nextCycle();

        // Contention: D first, I granted in the d_data_ok cycle even with d_req still high
        applyStimulus(1, 32'h1100, 0, 1, 0, 32'h2200, 0, 4'hF);
        #1 checkOutput("cont c0 i_stall", bus.i_stall, 1);
        checkOutput("cont c0 d_stall", bus.d_stall, 1);
        nextCycle(); memRespond(1, 0, 0);
        #1 checkOutput("cont c1 mem_addr", bus.mem_addr, 32'h2200);
        checkOutput("cont c1 mem_wstrb", bus.mem_wstrb, 0);
        checkOutput("cont c1 i_stall", bus.i_stall, 1);
        nextCycle(); memRespond(0, 1, 32'hCAFEF00D);
        nextCycle(); memRespond(0, 0, 0);
        #1 checkOutput("cont c3 d_data_ok", bus.d_data_ok, 1);
        checkOutput("cont c3 d_rdata", bus.d_rdata, 32'hCAFEF00D);
        checkOutput("cont c3 d_stall", bus.d_stall, 0);
        checkOutput("cont c3 i_stall", bus.i_stall, 1);
        nextCycle(); memRespond(1, 0, 0);
        applyStimulus(1, 32'h1100, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("cont c4 mem_req", bus.mem_req, 1);
        checkOutput("cont c4 mem_addr", bus.mem_addr, 32'h1100);
        nextCycle(); memRespond(0, 1, 32'h0BADF00D);
        nextCycle(); memRespond(0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("cont c6 i_data_ok", bus.i_data_ok, 1);
        checkOutput("cont c6 i_rdata", bus.i_rdata, 32'h0BADF00D);
        nextCycle();

        // Cancel during DATA, then a fresh fetch completes normally
        applyStimulus(1, 32'h1500, 0, 0, 0, 0, 0, 0);
        nextCycle(); memRespond(1, 0, 0);
        #1 checkOutput("cancel c1 mem_addr", bus.mem_addr, 32'h1500);
        nextCycle(); memRespond(0, 0, 0);
        applyStimulus(1, 32'h1500, 1, 0, 0, 0, 0, 0);
        #1 checkOutput("cancel c2 mem_req", bus.mem_req, 0);
        nextCycle(); memRespond(0, 1, 32'h11111111);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle(); memRespond(0, 0, 0);
        applyStimulus(1, 32'h3000, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("cancel c4 i_data_ok", bus.i_data_ok, 0);
        checkOutput("cancel c4 i_rdata", bus.i_rdata, 32'h0BADF00D);
        checkOutput("cancel c4 i_stall", bus.i_stall, 1);
        nextCycle(); memRespond(1, 0, 0);
        #1 checkOutput("cancel c5 mem_req", bus.mem_req, 1);
        checkOutput("cancel c5 mem_addr", bus.mem_addr, 32'h3000);
        nextCycle(); memRespond(0, 1, 32'h33333333);
        nextCycle(); memRespond(0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("cancel c7 i_data_ok", bus.i_data_ok, 1);
        checkOutput("cancel c7 i_rdata", bus.i_rdata, 32'h33333333);
        nextCycle();

        // Reset during ADDR, then a stray data_ok
        applyStimulus(0, 0, 0, 1, 0, 32'h4000, 0, 0);
        nextCycle();
        rst = 1'b1;
        #1 checkOutput("rstmid c1 mem_req", bus.mem_req, 1);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        memRespond(0, 1, 32'hFFFFFFFF);
        #1 checkOutput("rstmid c2 mem_req", bus.mem_req, 0);
        checkOutput("rstmid c2 d_rdata", bus.d_rdata, 0);
        checkOutput("rstmid c2 i_rdata", bus.i_rdata, 0);
        nextCycle(); memRespond(0, 0, 0);
        #1 checkOutput("rstmid c3 d_data_ok", bus.d_data_ok, 0);
        checkOutput("rstmid c3 mem_req", bus.mem_req, 0);
        checkOutput("rstmid c3 mem_addr", bus.mem_addr, 0);

        // Randomized traffic against the transaction-level model
        iPend = 0; dPend = 0; dWr = 0; iAddr = 0; dAddr = 0; dWdata = 0; dWstrb = 0;
        txnActive = 0; txnD = 0; txnWr = 0; txnPhase = 0; txnAddr = 0; txnWdata = 0; txnWstrb = 0;
        pulseI = 0; pulseD = 0; pendData = 0; lastI = 0; lastD = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nextCycle();
            expI = pulseI;
            expD = pulseD;
            if (expI) begin lastI = pendData; iPend = 0; end
            if (expD) begin lastD = pendData; dPend = 0; end
            if (!iPend && $urandom_range(0, 2) == 0) begin
                iPend = 1; iAddr = $urandom;
            end
            if (!dPend && $urandom_range(0, 2) == 0) begin
                dPend = 1; dWr = 1'($urandom_range(0, 1)); dAddr = $urandom;
                dWdata = $urandom; dWstrb = 4'($urandom_range(0, 15));
            end
            applyStimulus(iPend, iAddr, 0, dPend, dWr, dAddr, dWdata, dWstrb);

            grantI = 0; grantD = 0;
            if (!txnActive) begin
                candI = iPend && !expI;
                candD = dPend && !expD;
`ifdef ARB_FAIR_EN
                if (candI && (!candD || fairCnt == FAIR_LIMIT)) grantI = 1;
                else if (candD) grantD = 1;
                if (grantI) fairCnt = 0;
                else if (grantD && candI) fairCnt++;
`else
                if (candD) grantD = 1;
                else if (candI) grantI = 1;
`endif
            end

            addrOk = 0; dataOk = 0; rd = $urandom;
            if (txnActive && txnPhase == 1) begin
                addrOk = 1'($urandom_range(0, 1));
                dataOk = ($urandom_range(0, 3) == 0);
            end else if (txnActive && txnPhase == 2) begin
                dataOk = 1'($urandom_range(0, 1));
            end else begin
                dataOk = ($urandom_range(0, 4) == 0);
            end
            memRespond(addrOk, dataOk, rd);

            expMemReq = txnActive && txnPhase == 1;
            #1 checkOutput("rnd mem_req", bus.mem_req, expMemReq);
            if (expMemReq) begin
                checkOutput("rnd mem_addr", bus.mem_addr, txnAddr);
                checkOutput("rnd mem_wr", bus.mem_wr, txnWr);
                checkOutput("rnd mem_wstrb", bus.mem_wstrb, txnWstrb);
                if (txnWr) checkOutput("rnd mem_wdata", bus.mem_wdata, txnWdata);
            end
            checkOutput("rnd i_data_ok", bus.i_data_ok, expI);
            checkOutput("rnd d_data_ok", bus.d_data_ok, expD);
            checkOutput("rnd i_rdata", bus.i_rdata, lastI);
            checkOutput("rnd d_rdata", bus.d_rdata, lastD);
            checkOutput("rnd i_stall", bus.i_stall, iPend && !expI);
            checkOutput("rnd d_stall", bus.d_stall, dPend && !expD);

            pulseI = 0; pulseD = 0;
            if (txnActive && txnPhase == 2 && dataOk) begin
                txnActive = 0;
                pendData  = rd;
                if (txnD) pulseD = 1;
                else      pulseI = 1;
            end else if (txnActive && txnPhase == 1 && addrOk) begin
                txnPhase = 2;
            end else if (grantD) begin
                txnActive = 1; txnPhase = 1; txnD = 1; txnAddr = dAddr; txnWr = dWr;
                txnWdata = dWdata; txnWstrb = dWr ? dWstrb : 4'h0;
            end else if (grantI) begin
                txnActive = 1; txnPhase = 1; txnD = 0; txnAddr = iAddr; txnWr = 0;
                txnWstrb = 4'h0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
